// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
package regfile_write_arbiter_pkg;

  // Default age-stamp width; must satisfy 2^W > 2*FIFO_DEPTH+1.
  localparam int WB_SEQ_WIDTH = 3;

  // Writeback requester identity, used for grant and last_grant.
  typedef enum logic {
    WB_REQ_EX  = 1'b0,
    WB_REQ_LSU = 1'b1
  } wb_requester_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_req_fifo.sv
// Per-requester writeback FIFO: circular buffer holding {addr, data, seq}.
// Per-slot valid bits and addresses are exported for pending-mask generation.
module wb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int SW    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic [SW-1:0]            push_seq_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic [SW-1:0]            head_seq_o,
  output logic [DEPTH-1:0]         ent_vld_o,
  output logic [DEPTH-1:0][AW-1:0] ent_addr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0][SW-1:0] seq_q;
  logic [DEPTH-1:0]         vld_q;
  logic [PW-1:0]            wr_ptr_q;
  logic [PW-1:0]            rd_ptr_q;
  logic                     do_push;
  logic                     do_pop;

  // Occupied slots are contiguous, so all-valid means full and none-valid means empty.
  assign full_o      = &vld_q;
  assign empty_o     = ~|vld_q;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_seq_o  = seq_q[rd_ptr_q];
  assign ent_vld_o   = vld_q;
  assign ent_addr_o  = addr_q;

  // Push writes the tail slot, pop retires the head slot; they never alias.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      seq_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        addr_q[wr_ptr_q] <= push_addr_i;
        data_q[wr_ptr_q] <= push_data_i;
        seq_q[wr_ptr_q]  <= push_seq_i;
        vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between EX and LSU writeback.
// Round-robin between distinct destinations, age-ordered for the same destination.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int SEQ_WIDTH  = WB_SEQ_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ex_valid_ip,
  input  logic [ADDR_WIDTH-1:0]      ex_addr_ip,
  input  logic [DATA_WIDTH-1:0]      ex_data_ip,
  output logic                       ex_ready_op,
  input  logic                       lsu_valid_ip,
  input  logic [ADDR_WIDTH-1:0]      lsu_addr_ip,
  input  logic [DATA_WIDTH-1:0]      lsu_data_ip,
  output logic                       lsu_ready_op,
  output logic [ADDR_WIDTH-1:0]      rf_waddr_op,
  output logic [DATA_WIDTH-1:0]      rf_wdata_op,
  output logic                       rf_we_op,
  output logic [(1<<ADDR_WIDTH)-1:0] pending_mask_op,
  output logic                       idle_op
);

  localparam int NREG     = 1 << ADDR_WIDTH;
  localparam int SEQ_HALF = 1 << (SEQ_WIDTH - 1);

  logic                                 ex_full, ex_empty, lsu_full, lsu_empty;
  logic                                 ex_push, lsu_push, ex_pop, lsu_pop;
  logic [ADDR_WIDTH-1:0]                ex_head_addr, lsu_head_addr;
  logic [DATA_WIDTH-1:0]                ex_head_data, lsu_head_data;
  logic [SEQ_WIDTH-1:0]                 ex_head_seq, lsu_head_seq;
  logic [FIFO_DEPTH-1:0]                ex_ent_vld, lsu_ent_vld;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ex_ent_addr, lsu_ent_addr;
  logic [SEQ_WIDTH-1:0]                 seq_q, seq_d, ex_stamp, seq_diff;
  logic                                 lsu_older;
  logic                                 grant_vld;
  wb_requester_e                        grant, last_q, last_d;
  logic                                 rf_we_q;
  logic [ADDR_WIDTH-1:0]                rf_waddr_q;
  logic [DATA_WIDTH-1:0]                rf_wdata_q;
  logic [NREG-1:0]                      pending_mask;

  // Ready depends only on registered occupancy; x0 writes handshake but are dropped.
  assign ex_ready_op  = ~ex_full;
  assign lsu_ready_op = ~lsu_full;
  assign ex_push      = ex_valid_ip & ~ex_full & (|ex_addr_ip);
  assign lsu_push     = lsu_valid_ip & ~lsu_full & (|lsu_addr_ip);

  // LSU counts as older when both stamp together, so EX takes seq+1.
  assign ex_stamp = seq_q + SEQ_WIDTH'(lsu_push);
  assign seq_d    = seq_q + SEQ_WIDTH'(lsu_push) + SEQ_WIDTH'(ex_push);

  // Wrap-safe age compare: LSU older iff (ex - lsu) mod 2^W in [1, half).
  assign seq_diff  = ex_head_seq - lsu_head_seq;
  assign lsu_older = (seq_diff != '0) && (seq_diff < SEQ_WIDTH'(SEQ_HALF));

  wb_req_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .SW(SEQ_WIDTH)) u_ex_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (ex_push),
    .push_addr_i (ex_addr_ip),
    .push_data_i (ex_data_ip),
    .push_seq_i  (ex_stamp),
    .pop_i       (ex_pop),
    .full_o      (ex_full),
    .empty_o     (ex_empty),
    .head_addr_o (ex_head_addr),
    .head_data_o (ex_head_data),
    .head_seq_o  (ex_head_seq),
    .ent_vld_o   (ex_ent_vld),
    .ent_addr_o  (ex_ent_addr)
  );

  wb_req_fifo #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .SW(SEQ_WIDTH)) u_lsu_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (lsu_push),
    .push_addr_i (lsu_addr_ip),
    .push_data_i (lsu_data_ip),
    .push_seq_i  (seq_q),
    .pop_i       (lsu_pop),
    .full_o      (lsu_full),
    .empty_o     (lsu_empty),
    .head_addr_o (lsu_head_addr),
    .head_data_o (lsu_head_data),
    .head_seq_o  (lsu_head_seq),
    .ent_vld_o   (lsu_ent_vld),
    .ent_addr_o  (lsu_ent_addr)
  );

  // Head arbitration: age order on same destination, round-robin otherwise.
  always_comb begin
    grant_vld = 1'b0;
    grant     = WB_REQ_EX;
    last_d    = last_q;
    if (!ex_empty && !lsu_empty) begin
      grant_vld = 1'b1;
      if (ex_head_addr == lsu_head_addr) begin
        grant = lsu_older ? WB_REQ_LSU : WB_REQ_EX;
      end else begin
        grant  = (last_q == WB_REQ_EX) ? WB_REQ_LSU : WB_REQ_EX;
        last_d = grant;
      end
    end else if (!ex_empty) begin
      grant_vld = 1'b1;
      grant     = WB_REQ_EX;
    end else if (!lsu_empty) begin
      grant_vld = 1'b1;
      grant     = WB_REQ_LSU;
    end
  end

  assign ex_pop  = grant_vld & (grant == WB_REQ_EX);
  assign lsu_pop = grant_vld & (grant == WB_REQ_LSU);

  // Stamp counter, round-robin pointer and the registered write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq_q      <= '0;
      last_q     <= WB_REQ_LSU;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      seq_q   <= seq_d;
      last_q  <= last_d;
      rf_we_q <= grant_vld;
      if (grant_vld) begin
        rf_waddr_q <= (grant == WB_REQ_EX) ? ex_head_addr : lsu_head_addr;
        rf_wdata_q <= (grant == WB_REQ_EX) ? ex_head_data : lsu_head_data;
      end
    end
  end

  // Pending destinations: every queued entry plus the write on the port this cycle.
  always_comb begin
    pending_mask = '0;
    for (int e = 0; e < FIFO_DEPTH; e++) begin
      if (ex_ent_vld[e])  pending_mask[ex_ent_addr[e]]  = 1'b1;
      if (lsu_ent_vld[e]) pending_mask[lsu_ent_addr[e]] = 1'b1;
    end
    if (rf_we_q) pending_mask[rf_waddr_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign rf_we_op        = rf_we_q;
  assign rf_waddr_op     = rf_waddr_q;
  assign rf_wdata_op     = rf_wdata_q;
  assign pending_mask_op = pending_mask;
  assign idle_op         = ex_empty & lsu_empty & ~rf_we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-derived write orders.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef logic [AW+DW-1:0] wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid_ip, lsu_valid_ip;
  logic [AW-1:0] ex_addr_ip, lsu_addr_ip;
  logic [DW-1:0] ex_data_ip, lsu_data_ip;
  logic          ex_ready_op, lsu_ready_op;
  logic [AW-1:0] rf_waddr_op;
  logic [DW-1:0] rf_wdata_op;
  logic          rf_we_op;
  logic [31:0]   pending_mask_op;
  logic          idle_op;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_cnt = 0;
  int ex_low_seen;
  logic [31:0] mask_acc;

  wr_t           wq[$];
  int            wc[$];
  wr_t           exp_q[$];
  logic [AW-1:0] ea[$], la[$];
  logic [DW-1:0] ed[$], ld[$];

  regfile_write_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .ex_valid_ip     (ex_valid_ip),
    .ex_addr_ip      (ex_addr_ip),
    .ex_data_ip      (ex_data_ip),
    .ex_ready_op     (ex_ready_op),
    .lsu_valid_ip    (lsu_valid_ip),
    .lsu_addr_ip     (lsu_addr_ip),
    .lsu_data_ip     (lsu_data_ip),
    .lsu_ready_op    (lsu_ready_op),
    .rf_waddr_op     (rf_waddr_op),
    .rf_wdata_op     (rf_wdata_op),
    .rf_we_op        (rf_we_op),
    .pending_mask_op (pending_mask_op),
    .idle_op         (idle_op)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt = cyc_cnt + 1;

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clock) begin
    mask_acc = mask_acc | pending_mask_op;
    if (!reset && rf_we_op) begin
      wq.push_back({rf_waddr_op, rf_wdata_op});
      wc.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs;
    wq.delete(); wc.delete(); exp_q.delete();
    ea.delete(); ed.delete(); la.delete(); ld.delete();
    mask_acc = '0;
  endtask

  task automatic do_reset;
    ex_valid_ip = 1'b0; lsu_valid_ip = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    clear_logs;
  endtask

  // Drives both request lists with hold-until-accepted semantics.
  task automatic stream(input int budget, output int cycles);
    int ei, li, cyc;
    logic exr, lr;
    ei = 0; li = 0; cyc = 0;
    while ((ei < ea.size() || li < la.size()) && cyc < budget) begin
      ex_valid_ip  = (ei < ea.size());
      lsu_valid_ip = (li < la.size());
      if (ex_valid_ip)  begin ex_addr_ip  = ea[ei]; ex_data_ip  = ed[ei]; end
      if (lsu_valid_ip) begin lsu_addr_ip = la[li]; lsu_data_ip = ld[li]; end
      exr = ex_ready_op; lr = lsu_ready_op;
      tick;
      cyc++;
      if (ex_valid_ip && exr)  ei++;
      if (lsu_valid_ip && lr)  li++;
      if (!ex_ready_op) ex_low_seen = 1;
    end
    ex_valid_ip = 1'b0; lsu_valid_ip = 1'b0;
    cycles = cyc;
    chk("stream_all_accepted", (ei == ea.size()) && (li == la.size()), 1'b1);
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (!idle_op && c < budget) begin tick; c++; end
    chk("drain_to_idle", idle_op, 1'b1);
  endtask

  task automatic check_writes(input string tag);
    chk($sformatf("%s_count", tag), wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
  endtask

  initial begin
    int cyc;
    ex_valid_ip = 1'b0; lsu_valid_ip = 1'b0;
    ex_addr_ip = '0; lsu_addr_ip = '0; ex_data_ip = '0; lsu_data_ip = '0;
    mask_acc = '0;
    ex_low_seen = 0;

    // Reset state
    tick; tick;
    chk("rst_we", rf_we_op, 1'b0);
    chk("rst_waddr", rf_waddr_op, 0);
    chk("rst_wdata", rf_wdata_op, 0);
    chk("rst_mask", pending_mask_op, 0);
    chk("rst_ex_ready", ex_ready_op, 1'b1);
    chk("rst_lsu_ready", lsu_ready_op, 1'b1);
    chk("rst_idle", idle_op, 1'b1);
    reset = 1'b0;
    tick;
    clear_logs;

    // Single EX write x5=0x11: two-cycle latency, pending bit lifetime
    ex_valid_ip = 1'b1; ex_addr_ip = 5; ex_data_ip = 32'h11;
    tick;
    ex_valid_ip = 1'b0;
    chk("t1_c1_mask", pending_mask_op, 32'h20);
    chk("t1_c1_we", rf_we_op, 1'b0);
    chk("t1_c1_idle", idle_op, 1'b0);
    tick;
    chk("t1_c2_we", rf_we_op, 1'b1);
    chk("t1_c2_waddr", rf_waddr_op, 5);
    chk("t1_c2_wdata", rf_wdata_op, 32'h11);
    chk("t1_c2_mask", pending_mask_op, 32'h20);
    tick;
    chk("t1_c3_we", rf_we_op, 1'b0);
    chk("t1_c3_mask", pending_mask_op, 0);
    chk("t1_c3_idle", idle_op, 1'b1);
    chk("t1_c3_waddr_hold", rf_waddr_op, 5);

    // Same register, same cycle, from reset: LSU is older and wins despite round-robin
    do_reset;
    ea.push_back(7); ed.push_back(32'h2);
    la.push_back(7); ld.push_back(32'h1);
    stream(10, cyc);
    drain(10);
    exp_q.push_back({5'd7, 32'h1});
    exp_q.push_back({5'd7, 32'h2});
    check_writes("same_reg");

    // Alternating distinct pairs: EX, LSU, EX, ... one write per cycle
    do_reset;
    for (int i = 0; i < 4; i++) begin
      ea.push_back(AW'(8 + i));  ed.push_back(32'hA0 + i);
      la.push_back(AW'(16 + i)); ld.push_back(32'hB0 + i);
    end
    stream(30, cyc);
    drain(20);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({AW'(8 + i), 32'hA0 + i});
      exp_q.push_back({AW'(16 + i), 32'hB0 + i});
    end
    check_writes("alt");
    if (wc.size() == 8) chk("alt_back_to_back", wc[7] - wc[0], 7);
    else chk("alt_write_log_len", wc.size(), 8);

    // EX held valid 6 writes against a flooded LSU: backpressure, in-order drain
    do_reset;
    ex_low_seen = 0;
    for (int i = 0; i < 6; i++) begin ea.push_back(AW'(8 + i));  ed.push_back(32'h100 + i); end
    for (int i = 0; i < 8; i++) begin la.push_back(AW'(20 + i)); ld.push_back(32'h200 + i); end
    stream(60, cyc);
    drain(30);
    chk("flood_ex_ready_dropped", ex_low_seen, 1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({AW'(8 + i), 32'h100 + i});
      exp_q.push_back({AW'(20 + i), 32'h200 + i});
    end
    exp_q.push_back({5'd26, 32'h206});
    exp_q.push_back({5'd27, 32'h207});
    check_writes("flood");

    // x0 write: handshake in one cycle, never on the port or in the mask
    do_reset;
    ea.push_back(0); ed.push_back(32'h55);
    stream(5, cyc);
    chk("x0_accept_cycles", cyc, 1);
    tick; tick; tick;
    chk("x0_no_write", wq.size(), 0);
    chk("x0_mask_never", mask_acc, 0);
    chk("x0_idle", idle_op, 1'b1);

    // Reset with queued entries: everything discarded
    do_reset;
    ex_valid_ip = 1'b1; ex_addr_ip = 1; ex_data_ip = 32'hC1;
    lsu_valid_ip = 1'b1; lsu_addr_ip = 3; lsu_data_ip = 32'hC3;
    tick;
    ex_addr_ip = 2; ex_data_ip = 32'hC2;
    lsu_addr_ip = 4; lsu_data_ip = 32'hC4;
    tick;
    ex_valid_ip = 1'b0; lsu_valid_ip = 1'b0;
    chk("rq_pre_mask", pending_mask_op, 32'h1E);
    chk("rq_pre_we", rf_we_op, 1'b1);
    reset = 1'b1;
    #1;
    chk("rq_rst_we", rf_we_op, 1'b0);
    chk("rq_rst_mask", pending_mask_op, 0);
    chk("rq_rst_idle", idle_op, 1'b1);
    chk("rq_rst_ready", {ex_ready_op, lsu_ready_op}, 2'b11);
    tick;
    reset = 1'b0;
    tick; tick; tick; tick;
    chk("rq_no_issue", wq.size(), 0);
    chk("rq_idle_after", idle_op, 1'b1);

    // Stamp wrap: seven LSU writes bring seq to 7, then a same-register pair gets 7 and 0
    do_reset;
    for (int i = 1; i <= 7; i++) begin la.push_back(AW'(i)); ld.push_back(32'h30 + i); end
    stream(20, cyc);
    drain(20);
    clear_logs;
    ea.push_back(9); ed.push_back(32'hE2);
    la.push_back(9); ld.push_back(32'hA1);
    stream(10, cyc);
    drain(10);
    exp_q.push_back({5'd9, 32'hA1});
    exp_q.push_back({5'd9, 32'hE2});
    check_writes("wrap");
    chk("mask_bit0_never", mask_acc[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
